// File: rtl/golden_nonce_tx_arbiter.sv
// Round-robin arbiter funnelling per-core golden nonces through a small FIFO into one serial transmitter.
// Optional build macro DUPLICATE_FILTER_EN suppresses back-to-back retransmission of an identical nonce.
module golden_nonce_tx_arbiter #(
    parameter int NUM_CORES  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CORES-1:0]    nonce_valid,
    input  logic [32*NUM_CORES-1:0] nonce_in,
    input  logic                    new_work,
    input  logic                    tx_busy,
    output logic                    tx_send,
    output logic [31:0]             tx_word,
    output logic                    pending,
    output logic [7:0]              drop_count
);

    localparam int PTR_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = AW + 1;
    localparam int DROP_W = 5;

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_IDLE} tx_state_t;

    function automatic logic [DROP_W-1:0] popcount(input logic [NUM_CORES-1:0] v);
        logic [DROP_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_CORES; i++) n = n + DROP_W'(v[i]);
        return n;
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] acc, input logic [DROP_W-1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, acc} + 9'(inc);
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    logic [NUM_CORES-1:0] hold_vld_p0;
    logic [31:0]          hold_data_p0 [NUM_CORES];
    logic [PTR_W-1:0]     rr_ptr;

    logic [31:0]          fifo_mem_p1 [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CNT_W-1:0]     fifo_count;

    tx_state_t            state;
    logic                 timer;

    logic                 grant_vld;
    logic [PTR_W-1:0]     grant_idx;
    logic [NUM_CORES-1:0] taken;
    logic [NUM_CORES-1:0] drop_vec;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 pop;
    logic                 push;
    logic                 dup_hit;
    logic                 send_now;
    logic [31:0]          head;
    logic [DROP_W-1:0]    drop_inc;

    // Round-robin search starting at rr_ptr, wrapping past the last core.
    always_comb begin
        int idx;
        logic [PTR_W-1:0] idx_w;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        idx_w     = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CORES) idx = idx - NUM_CORES;
            idx_w = PTR_W'(idx);
            if (!grant_vld && hold_vld_p0[idx_w]) begin
                grant_vld = 1'b1;
                grant_idx = idx_w;
            end
        end
    end

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign head       = fifo_mem_p1[rd_ptr];
    // new_work discards everything queued, so nothing moves through the FIFO on that cycle.
    assign pop        = (state == IDLE) && !fifo_empty && !new_work;
    assign push       = grant_vld && (!fifo_full || pop) && !new_work;

`ifdef DUPLICATE_FILTER_EN
    logic [31:0] last_sent;
    assign dup_hit = pop && (head == last_sent);

    always_ff @(posedge clk) begin
        if (reset || new_work) last_sent <= 32'hFFFF_FFFF;
        else if (send_now)     last_sent <= head;
    end
`else
    assign dup_hit = 1'b0;
`endif

    assign send_now = pop && !dup_hit;

    always_comb begin
        taken    = '0;
        drop_vec = '0;
        if (push) taken[grant_idx] = 1'b1;
        for (int i = 0; i < NUM_CORES; i++)
            drop_vec[i] = nonce_valid[i] && hold_vld_p0[i] && !taken[i] && !new_work;
    end

    assign drop_inc = popcount(drop_vec) + DROP_W'(dup_hit);

    // Capture stage: strobe -> per-core hold register.
    always_ff @(posedge clk) begin
        if (reset || new_work) begin
            hold_vld_p0 <= '0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (nonce_valid[i] && (!hold_vld_p0[i] || taken[i])) hold_vld_p0[i] <= 1'b1;
                else if (taken[i])                                   hold_vld_p0[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CORES; i++)
            if (nonce_valid[i] && (!hold_vld_p0[i] || taken[i]))
                hold_data_p0[i] <= nonce_in[32*i +: 32];
    end

    always_ff @(posedge clk) begin
        if (reset)
            rr_ptr <= '0;
        else if (push)
            rr_ptr <= (int'(grant_idx) == NUM_CORES - 1) ? '0 : grant_idx + PTR_W'(1);
    end

    // Queue stage: granted hold -> FIFO.
    always_ff @(posedge clk) begin
        if (reset || new_work) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem_p1[wr_ptr] <= hold_data_p0[grant_idx];
    end

    // Transmit stage: FIFO head -> serial_transmit handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            tx_send <= 1'b0;
            tx_word <= '0;
            timer   <= 1'b0;
        end else begin
            tx_send <= 1'b0;
            case (state)
                IDLE: begin
                    if (send_now) begin
                        tx_word <= head;
                        tx_send <= 1'b1;
                        timer   <= 1'b0;
                        state   <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    // A transmitter that never answers must not wedge the queue.
                    if (tx_busy || timer) state <= WAIT_IDLE;
                    else                  timer <= 1'b1;
                end
                WAIT_IDLE: begin
                    if (!tx_busy) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
            pending    <= 1'b0;
        end else begin
            drop_count <= sat_add(drop_count, drop_inc);
            pending    <= !fifo_empty || (state != IDLE) || (|hold_vld_p0);
        end
    end

endmodule

// File: tb/tb_golden_nonce_tx_arbiter.sv
// Directed bench for golden_nonce_tx_arbiter with a small serial_transmit busy responder.
module tb_golden_nonce_tx_arbiter;

    localparam int NC = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [NC-1:0]   nonce_valid;
    logic [32*NC-1:0] nonce_in;
    logic            new_work;
    logic            tx_busy;
    logic            tx_send;
    logic [31:0]     tx_word;
    logic            pending;
    logic [7:0]      drop_count;

    golden_nonce_tx_arbiter #(.NUM_CORES(NC), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .nonce_valid(nonce_valid),
        .nonce_in   (nonce_in),
        .new_work   (new_work),
        .tx_busy    (tx_busy),
        .tx_send    (tx_send),
        .tx_word    (tx_word),
        .pending    (pending),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int busy_mode = 0;   // 0 auto responder, 1 forced high, 2 never busy
    int busy_cnt = 0;
    int strobe_cyc = 0;
    logic [31:0] sent_q[$];
    int          sent_cyc[$];

`ifdef DUPLICATE_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sent_word(input int i);
        if (i < sent_q.size()) return sent_q[i];
        return 32'hDEAD_DEAD;
    endfunction

    task automatic strobe(input logic [NC-1:0] mask, input logic [31:0] word, input int inc);
        nonce_valid = mask;
        for (int i = 0; i < NC; i++) nonce_in[32*i +: 32] = word + 32'(inc * i);
        strobe_cyc = cyc;
        tick();
        nonce_valid = '0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        repeat (3) tick();
        while (pending !== 1'b0 && n < 300) begin
            tick();
            n++;
        end
        check(tag, {31'd0, pending}, 32'd0);
    endtask

    // serial_transmit stand-in: busy rises the cycle after tx_send and lasts 3 cycles
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (busy_mode)
                1: begin tx_busy = 1'b1; busy_cnt = 0; end
                2: begin tx_busy = 1'b0; busy_cnt = 0; end
                default: begin
                    if (busy_cnt > 0) begin
                        tx_busy = 1'b1;
                        busy_cnt--;
                    end else begin
                        tx_busy = 1'b0;
                    end
                    if (tx_send === 1'b1) busy_cnt = 3;
                end
            endcase
        end
    end

    logic prev_send = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tx_send === 1'b1) begin
                check("no_b2b_send", {31'd0, prev_send}, 32'd0);
                sent_q.push_back(tx_word);
                sent_cyc.push_back(cyc);
            end
            prev_send = tx_send;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        nonce_valid = '0;
        nonce_in    = '0;
        new_work    = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_tx_send", {31'd0, tx_send}, 32'd0);
        check("rst_tx_word", tx_word, 32'd0);
        check("rst_pending", {31'd0, pending}, 32'd0);
        check("rst_drop", {24'd0, drop_count}, 32'd0);

        // single nonce, latency strobe N -> tx_send N+3
        strobe(8'h08, 32'h0000_318F, 0);
        tick();
        tick();
        check("t1_send_at_n3", {31'd0, tx_send}, 32'd1);
        check("t1_pending", {31'd0, pending}, 32'd1);
        wait_idle("t1_idle");
        check("t1_count", sent_q.size(), 32'd1);
        check("t1_word", sent_word(0), 32'h0000_318F);
        check("t1_latency", (sent_cyc.size() > 0) ? sent_cyc[0] - strobe_cyc : -1, 32'd3);

        // bring rr_ptr to 6, then 0,5,7 together -> 7,0,5
        strobe(8'h20, 32'h0000_0055, 0);
        wait_idle("t2_pre_idle");
        sent_q.delete();
        sent_cyc.delete();
        strobe(8'hA1, 32'h0000_0100, 1);
        wait_idle("t2_idle");
        check("t2_count", sent_q.size(), 32'd3);
        check("t2_first", sent_word(0), 32'h0000_0107);
        check("t2_second", sent_word(1), 32'h0000_0100);
        check("t2_third", sent_word(2), 32'h0000_0105);
        check("t2_drop", {24'd0, drop_count}, 32'd0);

        // FIFO full behind a stuck transmitter: A held, B dropped
        sent_q.delete();
        sent_cyc.delete();
        busy_mode = 1;
        strobe(8'h01, 32'h0000_00C0, 0);
        repeat (6) tick();
        strobe(8'h3A, 32'h0000_0200, 1);
        repeat (7) tick();
        strobe(8'h04, 32'h0000_000A, 0);
        strobe(8'h04, 32'h0000_000B, 0);
        repeat (3) tick();
        check("t3_drop", {24'd0, drop_count}, 32'd1);
        check("t3_sent_before_release", sent_q.size(), 32'd1);
        busy_mode = 0;
        wait_idle("t3_idle");
        check("t3_count", sent_q.size(), 32'd6);
        check("t3_second", sent_word(1), 32'h0000_0201);
        check("t3_last_is_A", sent_word(5), 32'h0000_000A);

        // new_work while in WAIT_IDLE with 3 queued
        sent_q.delete();
        sent_cyc.delete();
        busy_mode = 1;
        strobe(8'h0F, 32'h0000_0300, 1);
        repeat (8) tick();
        new_work = 1'b1;
        tick();
        new_work = 1'b0;
        repeat (2) tick();
        busy_mode = 0;
        wait_idle("t4_idle");
        check("t4_count", sent_q.size(), 32'd1);
        check("t4_word", sent_word(0), 32'h0000_0303);

        // transmitter never answers: timeout, next sent 4 cycles later
        sent_q.delete();
        sent_cyc.delete();
        busy_mode = 2;
        strobe(8'h50, 32'h0000_0400, 1);
        wait_idle("t5_idle");
        check("t5_count", sent_q.size(), 32'd2);
        check("t5_first", sent_word(0), 32'h0000_0404);
        check("t5_second", sent_word(1), 32'h0000_0406);
        check("t5_spacing", (sent_cyc.size() > 1) ? sent_cyc[1] - sent_cyc[0] : -1, 32'd4);
        busy_mode = 0;

        // identical nonce from two cores
        sent_q.delete();
        sent_cyc.delete();
        strobe(8'h12, 32'h0000_1234, 0);
        wait_idle("t6_idle");
        check("t6_count", sent_q.size(), FILT ? 32'd1 : 32'd2);
        check("t6_word", sent_word(0), 32'h0000_1234);
        check("t6_drop", {24'd0, drop_count}, FILT ? 32'd2 : 32'd1);

        // hammer all cores behind a stuck transmitter: drop_count saturates
        busy_mode = 1;
        nonce_valid = '1;
        repeat (100) tick();
        nonce_valid = '0;
        tick();
        check("sat_drop", {24'd0, drop_count}, 32'd255);
        check("sat_pending", {31'd0, pending}, 32'd1);

        // reset while a transmission is outstanding
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_tx_send", {31'd0, tx_send}, 32'd0);
        check("rst2_tx_word", tx_word, 32'd0);
        check("rst2_pending", {31'd0, pending}, 32'd0);
        check("rst2_drop", {24'd0, drop_count}, 32'd0);
        busy_mode = 0;
        repeat (5) tick();
        check("rst2_quiet", {31'd0, pending}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
